// File: rtl/vert_ucode_quicksort_pkg.sv
// Shared types and sizing for the vertical-microcode quicksort bank scheduler.
package vert_ucode_quicksort_pkg;
   localparam int N      = 16;
   localparam int W      = 32;
   localparam int BANK_N = 2;

   localparam int BANK_W = (BANK_N > 1) ? $clog2(BANK_N) : 1;
   localparam int ADDR_W = $clog2(N);
   localparam int N_W    = $clog2(N + 1);

   typedef logic [BANK_W-1:0] bank_n_t;
   typedef logic [N_W-1:0]    n_t;
   typedef logic [ADDR_W-1:0] addr_t;

   typedef enum logic [2:0] {
      BANK_IDLE,
      BANK_LOADING,
      BANK_READY,
      BANK_SORTING,
      BANK_SORTED,
      BANK_UNLOADING
   } bank_status_t;

   typedef struct packed {
      bank_status_t status;
      n_t           n;
      logic         error;
   } bank_state_t;

   typedef enum logic {ENQ_IDLE, ENQ_LOAD} enqueue_fsm_t;
   typedef enum logic {DEQ_IDLE, DEQ_EMIT} dequeue_fsm_t;

   typedef struct packed {
      bank_n_t enq;
      bank_n_t sort;
      bank_n_t deq;
   } sched_ptrs_t;

   typedef struct packed {
      logic [W-1:0] dat;
      logic         last;
      logic         err;
   } out_word_t;

   // Round-robin bank pointer advance; works for non power-of-two BANK_N.
   function automatic bank_n_t next_bank(input bank_n_t b);
      return (b == bank_n_t'(BANK_N - 1)) ? '0 : b + 1'b1;
   endfunction
endpackage

// File: rtl/vert_ucode_quicksort_out_skid.sv
// Two-entry valid/ready output buffer. The producer never pushes when full;
// the scheduler's read-credit check guarantees that.
module vert_ucode_quicksort_out_skid
   import vert_ucode_quicksort_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  out_word_t  push_word,
   output logic       out_vld,
   output out_word_t  out_word,
   input  logic       out_rdy,
   output logic [1:0] occ
);
   out_word_t  mem_q [2];
   logic       wp_q, rp_q;
   logic [1:0] occ_q;
   logic       pop;

   assign out_vld  = (occ_q != 2'd0);
   assign out_word = mem_q[rp_q];
   assign occ      = occ_q;
   assign pop      = out_vld & out_rdy;

   // Circular two-slot storage with occupancy count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wp_q     <= 1'b0;
         rp_q     <= 1'b0;
         occ_q    <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wp_q] <= push_word;
            wp_q        <= ~wp_q;
         end
         if (pop) rp_q <= ~rp_q;
         occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
      end
   end
endmodule

// File: rtl/vert_ucode_quicksort_bank_sched.sv
// Bank scheduler: loads input lists into banks, hands full banks to the sort
// engine in order, and drains sorted banks through a 2-entry output buffer.
module vert_ucode_quicksort_bank_sched
   import vert_ucode_quicksort_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_vld,
   input  logic [W-1:0] in_dat,
   input  logic         in_last,
   output logic         in_rdy,
   output logic         wr_en,
   output bank_n_t      wr_bank,
   output addr_t        wr_addr,
   output logic [W-1:0] wr_dat,
   output logic         rd_en,
   output bank_n_t      rd_bank,
   output addr_t        rd_addr,
   input  logic [W-1:0] rd_dat,
   output logic         sort_start,
   output bank_n_t      sort_bank,
   output n_t           sort_n,
   input  logic         sort_done,
   input  logic         sort_err,
   output logic         out_vld,
   output logic [W-1:0] out_dat,
   output logic         out_last,
   output logic         out_err,
   input  logic         out_rdy,
   output logic         busy
);
   bank_state_t  banks_q [BANK_N];
   bank_state_t  banks_d [BANK_N];
   sched_ptrs_t  ptrs_q, ptrs_d;
   enqueue_fsm_t enq_q, enq_d;
   dequeue_fsm_t deq_q, deq_d;
   n_t           cnt_q, cnt_d;
   n_t           rd_idx_q, rd_idx_d;
   logic         eng_busy_q, eng_busy_d;
   logic         start_q, start_d;
   bank_n_t      sbank_q, sbank_d;
   n_t           sn_q, sn_d;
   logic         rd_vld_q, rd_last_q, rd_last_d;
   logic         accept, pop;
   logic [1:0]   skid_occ;
   logic [2:0]   fill;
   out_word_t    ow;

   assign sort_start = start_q;
   assign sort_bank  = sbank_q;
   assign sort_n     = sn_q;
   assign out_dat    = ow.dat;
   assign out_last   = ow.last;
   assign out_err    = ow.err;

   vert_ucode_quicksort_out_skid u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (rd_vld_q),
      .push_word ({rd_dat, rd_last_q, banks_q[ptrs_q.deq].error}),
      .out_vld   (out_vld),
      .out_word  (ow),
      .out_rdy   (out_rdy),
      .occ       (skid_occ)
   );

   // Next-state for enqueue, dispatch and dequeue; each touches a distinct bank.
   always_comb begin
      banks_d    = banks_q;
      ptrs_d     = ptrs_q;
      enq_d      = enq_q;
      deq_d      = deq_q;
      cnt_d      = cnt_q;
      rd_idx_d   = rd_idx_q;
      eng_busy_d = eng_busy_q;
      start_d    = 1'b0;
      sbank_d    = sbank_q;
      sn_d       = sn_q;

      // enqueue: ready while a list is open or the target bank is free
      in_rdy  = ~rst & ((enq_q == ENQ_LOAD) | (banks_q[ptrs_q.enq].status == BANK_IDLE));
      accept  = in_vld & in_rdy;
      wr_en   = accept;
      wr_bank = ptrs_q.enq;
      wr_addr = addr_t'(cnt_q);
      wr_dat  = accept ? in_dat : '0;
      if (accept) begin
         banks_d[ptrs_q.enq].status = BANK_LOADING;
         enq_d = ENQ_LOAD;
         cnt_d = cnt_q + 1'b1;
         if (in_last || cnt_q == n_t'(N - 1)) begin
            banks_d[ptrs_q.enq].status = BANK_READY;
            banks_d[ptrs_q.enq].n      = cnt_q + 1'b1;
            ptrs_d.enq = next_bank(ptrs_q.enq);
            enq_d      = ENQ_IDLE;
            cnt_d      = '0;
         end
      end

      // dispatch: one bank at a time, strictly in pointer order
      if (!eng_busy_q && banks_q[ptrs_q.sort].status == BANK_READY) begin
         banks_d[ptrs_q.sort].status = BANK_SORTING;
         start_d    = 1'b1;
         sbank_d    = ptrs_q.sort;
         sn_d       = banks_q[ptrs_q.sort].n;
         eng_busy_d = 1'b1;
      end else if (eng_busy_q && sort_done) begin
         banks_d[sbank_q].status = BANK_SORTED;
         banks_d[sbank_q].error  = sort_err;
         ptrs_d.sort = next_bank(ptrs_q.sort);
         eng_busy_d  = 1'b0;
      end

      // dequeue: issue a read only if the buffer can absorb it after this cycle's pop
      pop       = out_vld & out_rdy;
      fill      = {1'b0, skid_occ} + {2'b0, rd_vld_q};
      rd_bank   = ptrs_q.deq;
      rd_addr   = addr_t'(rd_idx_q);
      rd_en     = (deq_q == DEQ_EMIT) && (rd_idx_q < banks_q[ptrs_q.deq].n) &&
                  (fill < 3'd2 + {2'b0, pop});
      rd_last_d = rd_en && (rd_idx_q == banks_q[ptrs_q.deq].n - 1'b1);
      case (deq_q)
         DEQ_IDLE: begin
            if (banks_q[ptrs_q.deq].status == BANK_SORTED) begin
               banks_d[ptrs_q.deq].status = BANK_UNLOADING;
               deq_d    = DEQ_EMIT;
               rd_idx_d = '0;
            end
         end
         default: begin
            if (rd_en) rd_idx_d = rd_idx_q + 1'b1;
            if (pop && out_last) begin
               banks_d[ptrs_q.deq] = '{BANK_IDLE, '0, 1'b0};
               ptrs_d.deq = next_bank(ptrs_q.deq);
               deq_d      = DEQ_IDLE;
            end
         end
      endcase

      busy = 1'b0;
      for (int i = 0; i < BANK_N; i++)
         if (banks_q[i].status != BANK_IDLE) busy = 1'b1;
   end

   // State registers; reset discards any read in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BANK_N; i++) banks_q[i] <= '{BANK_IDLE, '0, 1'b0};
         ptrs_q     <= '0;
         enq_q      <= ENQ_IDLE;
         deq_q      <= DEQ_IDLE;
         cnt_q      <= '0;
         rd_idx_q   <= '0;
         eng_busy_q <= 1'b0;
         start_q    <= 1'b0;
         sbank_q    <= '0;
         sn_q       <= '0;
         rd_vld_q   <= 1'b0;
         rd_last_q  <= 1'b0;
      end else begin
         banks_q    <= banks_d;
         ptrs_q     <= ptrs_d;
         enq_q      <= enq_d;
         deq_q      <= deq_d;
         cnt_q      <= cnt_d;
         rd_idx_q   <= rd_idx_d;
         eng_busy_q <= eng_busy_d;
         start_q    <= start_d;
         sbank_q    <= sbank_d;
         sn_q       <= sn_d;
         rd_vld_q   <= rd_en;
         rd_last_q  <= rd_last_d;
      end
   end
endmodule

// File: tb/tb_vert_ucode_quicksort_bank_sched.sv
// Bench for the quicksort bank scheduler: bank RAM and sort engine models,
// list-level reference model (chunking at in_last / N words, sorted output).
module tb_vert_ucode_quicksort_bank_sched;
   import vert_ucode_quicksort_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_vld, in_last, in_rdy;
   logic [W-1:0] in_dat;
   logic         wr_en, rd_en;
   bank_n_t      wr_bank, rd_bank, sort_bank;
   addr_t        wr_addr, rd_addr;
   logic [W-1:0] wr_dat, rd_dat, out_dat;
   logic         sort_start, sort_done, sort_err;
   n_t           sort_n;
   logic         out_vld, out_last, out_err, out_rdy, busy;

   always #5 clk = ~clk;

   vert_ucode_quicksort_bank_sched dut (
      .clk(clk), .rst(rst), .in_vld(in_vld), .in_dat(in_dat), .in_last(in_last),
      .in_rdy(in_rdy), .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
      .wr_dat(wr_dat), .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr),
      .rd_dat(rd_dat), .sort_start(sort_start), .sort_bank(sort_bank),
      .sort_n(sort_n), .sort_done(sort_done), .sort_err(sort_err),
      .out_vld(out_vld), .out_dat(out_dat), .out_last(out_last),
      .out_err(out_err), .out_rdy(out_rdy), .busy(busy)
   );

   typedef struct {
      logic [W-1:0] dat;
      logic         last;
      logic         err;
   } exp_t;

   typedef logic [W-1:0] word_q_t[$];

   exp_t         exp_q[$];
   int           len_q[$];
   bit           err_q[$];
   logic [W-1:0] cur[$];
   int           sn_log[$];
   logic [W-1:0] ram [BANK_N][N];
   int           mdl_bank = 0, disp_cnt = 0;
   int           n_chk = 0, n_fail = 0;
   int           words_seen = 0, sorts_seen = 0;
   int           rdy_mode = 0, eng_dmax = 3;
   bit           eng_hold = 0;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   // A closed chunk is sorted and queued for output; the engine consumes len/err.
   function automatic void close_chunk(input bit err);
      logic [W-1:0] s[$];
      exp_t e;
      s = cur;
      s.sort();
      for (int i = 0; i < s.size(); i++) begin
         e.dat  = s[i];
         e.last = (i == s.size() - 1);
         e.err  = err;
         exp_q.push_back(e);
      end
      len_q.push_back(s.size());
      err_q.push_back(err);
      mdl_bank = (mdl_bank + 1) % BANK_N;
      cur.delete();
   endfunction

   // Bank RAM: writes land at the negedge, read data appears one cycle after rd_en.
   initial begin
      bit           pend;
      logic [W-1:0] val;
      rd_dat = '0;
      forever begin
         @(negedge clk);
         pend = rd_en;
         val  = ram[rd_bank][rd_addr];
         if (wr_en) ram[wr_bank][wr_addr] = wr_dat;
         @(posedge clk); #1;
         rd_dat = pend ? val : 32'hDEAD_BEEF;
      end
   end

   // Sort engine: sorts the bank in RAM after a random delay, then pulses done.
   initial begin
      bit   act, er;
      int   wc, bk, nn;
      logic [W-1:0] tmp[$];
      sort_done = 0; sort_err = 0; act = 0; er = 0; wc = 0; bk = 0; nn = 0;
      forever begin
         @(posedge clk); #1;
         sort_done = 0; sort_err = 0;
         if (rst) act = 0;
         else if (act) begin
            chk("sort_start_overlap", sort_start, 0);
            if (eng_hold) ;
            else if (wc > 0) wc--;
            else begin
               tmp.delete();
               for (int i = 0; i < nn; i++) tmp.push_back(ram[bk][i]);
               tmp.sort();
               for (int i = 0; i < nn; i++) ram[bk][i] = tmp[i];
               sort_done = 1; sort_err = er; act = 0;
            end
         end else if (sort_start) begin
            chk("sort_bank", sort_bank, disp_cnt % BANK_N);
            if (len_q.size() == 0) begin
               chk("sort_start_unexpected", 1, 0);
               nn = 0; er = 0;
            end else begin
               nn = len_q.pop_front();
               er = err_q.pop_front();
               chk("sort_n", sort_n, nn);
            end
            bk = sort_bank;
            sn_log.push_back(int'(sort_n));
            sorts_seen++; disp_cnt++;
            act = 1; wc = $urandom_range(0, eng_dmax);
         end
      end
   end

   // Consumer ready pattern: 0 always, 1 repeating 1,0,0,1, 2 random.
   initial begin
      int ph;
      ph = 0; out_rdy = 0;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0:       out_rdy = 1;
            1:       out_rdy = (ph % 4 == 0) || (ph % 4 == 3);
            default: out_rdy = $urandom_range(0, 1);
         endcase
         ph++;
      end
   end

   // Output scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && out_vld && out_rdy) begin
            if (exp_q.size() == 0) chk("out_unexpected_word", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("out_dat", out_dat, e.dat);
               chk("out_last", out_last, e.last);
               chk("out_err", out_err, e.err);
            end
            words_seen++;
         end
      end
   end

   task automatic send_list(input word_q_t w, input bit use_last, input bit err);
      int t;
      for (int i = 0; i < w.size(); i++) begin
         in_vld = 1; in_dat = w[i]; in_last = use_last && (i == w.size() - 1);
         t = 0;
         @(negedge clk);
         while (!in_rdy && t < 3000) begin @(negedge clk); t++; end
         if (t >= 3000) begin
            chk("in_rdy_timeout", 0, 1);
            in_vld = 0; in_last = 0;
            return;
         end
         chk("wr_en", wr_en, 1);
         chk("wr_bank", wr_bank, mdl_bank);
         chk("wr_addr", wr_addr, cur.size());
         chk("wr_dat", wr_dat, w[i]);
         cur.push_back(w[i]);
         if (in_last || cur.size() == N) close_chunk(err);
         @(posedge clk); #1;
      end
      in_vld = 0; in_last = 0;
   endtask

   task automatic wait_drain(input string nm);
      int t;
      t = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || busy) && t < 4000) begin @(negedge clk); t++; end
      chk({nm, "_drain_timeout"}, t < 4000, 1);
      @(posedge clk); #1;
   endtask

   task automatic check_reset_outputs();
      chk("rst_in_rdy", in_rdy, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_sort_start", sort_start, 0);
      chk("rst_sort_bank", sort_bank, 0);
      chk("rst_sort_n", sort_n, 0);
      chk("rst_out_vld", out_vld, 0);
      chk("rst_out_dat", out_dat, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_err", out_err, 0);
      chk("rst_busy", busy, 0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1;
      @(negedge clk);
      exp_q.delete(); len_q.delete(); err_q.delete(); cur.delete();
      mdl_bank = 0; disp_cnt = 0;
      check_reset_outputs();
      repeat (2) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("post_rst_in_rdy", in_rdy, 1);
      @(posedge clk); #1;
   endtask

   typedef struct {
      int len; bit use_last; bit err; int rdy;
      int exp_n0; int exp_sorts; int exp_words;
   } vec_t;

   initial begin
      vec_t    vt[7];
      word_q_t w;
      int      s0, w0, t;

      vt[0] = '{4,  1, 0, 0, 4,  1, 4};
      vt[1] = '{3,  1, 1, 1, 3,  1, 3};
      vt[2] = '{17, 1, 0, 0, 16, 2, 17};
      vt[3] = '{5,  1, 0, 1, 5,  1, 5};
      vt[4] = '{1,  1, 1, 2, 1,  1, 1};
      vt[5] = '{16, 1, 0, 2, 16, 1, 16};
      vt[6] = '{16, 0, 1, 0, 16, 1, 16};

      rst = 1; in_vld = 0; in_dat = '0; in_last = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs();
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      chk("post_rst_in_rdy", in_rdy, 1);
      @(posedge clk); #1;

      // table-driven lists
      for (int k = 0; k < 7; k++) begin
         rdy_mode = vt[k].rdy;
         w.delete();
         if (k == 0) w = '{32'd3, 32'd1, 32'd2, 32'd0};
         else for (int i = 0; i < vt[k].len; i++) w.push_back($urandom_range(0, 50));
         s0 = sorts_seen; w0 = words_seen;
         send_list(w, vt[k].use_last, vt[k].err);
         wait_drain($sformatf("vec%0d", k));
         chk($sformatf("vec%0d_sorts", k), sorts_seen - s0, vt[k].exp_sorts);
         chk($sformatf("vec%0d_words", k), words_seen - w0, vt[k].exp_words);
         chk($sformatf("vec%0d_n0", k), (sn_log.size() > s0) ? sn_log[s0] : -1, vt[k].exp_n0);
         chk($sformatf("vec%0d_busy", k), busy, 0);
      end

      // both banks filled with the engine stalled
      rdy_mode = 0; eng_hold = 1; s0 = sorts_seen;
      w = '{32'd9, 32'd7, 32'd8};
      send_list(w, 1, 0);
      w = '{32'd5, 32'd6, 32'd4};
      send_list(w, 1, 1);
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("stall_in_rdy", in_rdy, 0);
      chk("stall_busy", busy, 1);
      chk("stall_one_dispatch", sorts_seen - s0, 1);
      @(posedge clk); #1;
      eng_hold = 0;
      wait_drain("stall");
      chk("stall_sorts", sorts_seen - s0, 2);

      // random concurrent traffic
      rdy_mode = 2; eng_dmax = 6;
      for (int k = 0; k < 30; k++) begin
         w.delete();
         t = $urandom_range(1, 20);
         for (int i = 0; i < t; i++) w.push_back($urandom);
         send_list(w, (k == 29) ? 1'b1 : 1'(($urandom_range(0, 3)) != 0), 1'($urandom_range(0, 1)));
      end
      wait_drain("random");

      // reset in the middle of an unload
      rdy_mode = 2; w0 = words_seen;
      w.delete();
      for (int i = 0; i < 16; i++) w.push_back($urandom_range(0, 1000));
      send_list(w, 1, 0);
      t = 0;
      while (words_seen < w0 + 2 && t < 2000) begin @(negedge clk); t++; end
      chk("midunload_reached", t < 2000, 1);
      do_reset();
      rdy_mode = 0;
      w = '{32'd40, 32'd10, 32'd30, 32'd20};
      send_list(w, 1, 0);
      wait_drain("post_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
